// File: rtl/maxpool_row_sequencer_pkg.sv
// Shared types and constants for the row-serial 2x2/stride-2 binary max-pool
// stage: FSM state encoding, default frame size and the in->out size rule.
package maxpool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EVEN,
        ODD,
        OUT,
        DONE
    } state_t;

    localparam int unsigned DEF_IMG_IN_SIZE = 28;

    // Pooled map edge length for a given input edge length (stride 2).
    function automatic int unsigned out_size(input int unsigned in_size);
        return in_size / 2;
    endfunction

endpackage

// File: rtl/maxpool_row_sequencer_if.sv
// Row streaming bundle for the max-pool sequencer.
//   in_row_valid/in_row_ready/in_row_data : one input row per beat
//   out_row_valid/out_row_ready/out_row_data/out_row_last : one pooled row per beat
// master = upstream/downstream environment side, slave = sequencer side.
interface maxpool_row_sequencer_if
    import maxpool_pkg::*;
#(
    parameter int unsigned IMG_IN_SIZE  = DEF_IMG_IN_SIZE,
    parameter int unsigned IMG_OUT_SIZE = out_size(IMG_IN_SIZE)
);
    logic                    in_row_valid;
    logic                    in_row_ready;
    logic [IMG_IN_SIZE-1:0]  in_row_data;
    logic                    out_row_valid;
    logic                    out_row_ready;
    logic [IMG_OUT_SIZE-1:0] out_row_data;
    logic                    out_row_last;

    modport master (
        output in_row_valid, in_row_data, out_row_ready,
        input  in_row_ready, out_row_valid, out_row_data, out_row_last
    );

    modport slave (
        input  in_row_valid, in_row_data, out_row_ready,
        output in_row_ready, out_row_valid, out_row_data, out_row_last
    );

endinterface

// File: rtl/maxpool_row_sequencer_reduce.sv
// maxpool_row_reduce: combinational 2x2 window OR over a pair of input rows.
//   even_row   : first row of the pair (bit c = column c)
//   odd_row    : second row of the pair
//   pooled_row : bit c = even[2c] | even[2c+1] | odd[2c] | odd[2c+1]
module maxpool_row_reduce #(
    parameter int unsigned IMG_IN_SIZE = 28
) (
    input  logic [IMG_IN_SIZE-1:0]   even_row,
    input  logic [IMG_IN_SIZE-1:0]   odd_row,
    output logic [IMG_IN_SIZE/2-1:0] pooled_row
);
    logic [IMG_IN_SIZE-1:0] col_or;

    always_comb begin
        col_or     = even_row | odd_row;
        pooled_row = '0;
        for (int unsigned c = 0; c < IMG_IN_SIZE / 2; c++) begin
            pooled_row[c] = col_or[2*c] | col_or[2*c+1];
        end
    end

endmodule

// File: rtl/maxpool_row_sequencer.sv
// maxpool_row_sequencer: row-serial controller for the binary 2x2/stride-2
// max-pool stage. Pairs consecutive input rows, ORs each 2x2 window and emits
// one pooled row per beat, flagging the last row and pulsing frame_done.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a frame (sampled only in IDLE)
//   abort       : synchronous abort back to IDLE, highest priority
//   row_if      : input/output row handshakes (slave modport)
//   busy        : high outside IDLE
//   frame_done  : one-cycle pulse after the last pooled row handshake
module maxpool_row_sequencer
    import maxpool_pkg::*;
#(
    parameter int unsigned IMG_IN_SIZE  = DEF_IMG_IN_SIZE,
    parameter int unsigned IMG_OUT_SIZE = out_size(IMG_IN_SIZE),
    parameter int unsigned CNT_W        = $clog2(IMG_OUT_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    maxpool_row_sequencer_if.slave row_if,
    output logic                   busy,
    output logic                   frame_done
);

    if ((IMG_IN_SIZE % 2) != 0) begin : g_size_check
        $error("maxpool_row_sequencer: IMG_IN_SIZE must be even");
    end

    state_t                  state;
    state_t                  state_nx;
    logic [CNT_W-1:0]        row_cnt;
    logic [IMG_IN_SIZE-1:0]  even_row;
    logic [IMG_OUT_SIZE-1:0] pooled;
    logic [IMG_OUT_SIZE-1:0] out_data;
    logic                    last_row;
    logic                    in_rdy;
    logic                    out_vld;
    logic                    out_last;

    assign last_row = (row_cnt == CNT_W'(IMG_OUT_SIZE - 1));

    maxpool_row_reduce #(
        .IMG_IN_SIZE (IMG_IN_SIZE)
    ) u_reduce (
        .even_row   (even_row),
        .odd_row    (row_if.in_row_data),
        .pooled_row (pooled)
    );

    // Handshake outputs decode from state only, so in_row_ready never
    // depends on in_row_valid.
    always_comb begin
        state_nx   = state;
        in_rdy     = 1'b0;
        out_vld    = 1'b0;
        out_last   = 1'b0;
        frame_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nx = EVEN;
            end
            EVEN: begin
                in_rdy = 1'b1;
                if (row_if.in_row_valid) state_nx = ODD;
            end
            ODD: begin
                in_rdy = 1'b1;
                if (row_if.in_row_valid) state_nx = OUT;
            end
            OUT: begin
                out_vld  = 1'b1;
                out_last = last_row;
                if (row_if.out_row_ready) state_nx = last_row ? DONE : EVEN;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    assign row_if.in_row_ready  = in_rdy;
    assign row_if.out_row_valid = out_vld;
    assign row_if.out_row_last  = out_last;
    assign row_if.out_row_data  = out_data;

    // A handshake landing in the same cycle as abort is dropped: no capture,
    // no counter advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row_cnt  <= '0;
            even_row <= '0;
            out_data <= '0;
        end else begin
            state <= state_nx;
            if (abort) begin
                row_cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (start) row_cnt <= '0;
                    EVEN: if (row_if.in_row_valid) even_row <= row_if.in_row_data;
                    ODD:  if (row_if.in_row_valid) out_data <= pooled;
                    OUT:  if (row_if.out_row_ready && !last_row) row_cnt <= row_cnt + CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maxpool_row_sequencer.sv
// Self-checking bench for maxpool_row_sequencer: a 28-wide and a 4-wide
// instance share clock and reset; row producers feed source queues, and
// monitors compare pooled rows against a scoreboard filled at stimulus time.
module tb_maxpool_row_sequencer;

    localparam int unsigned W28 = 28;
    localparam int unsigned O28 = 14;
    localparam int unsigned W4  = 4;
    localparam int unsigned O4  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic start28 = 1'b0, abort28 = 1'b0, busy28, done28;
    logic start4  = 1'b0, abort4  = 1'b0, busy4,  done4;

    maxpool_row_sequencer_if #(.IMG_IN_SIZE(W28)) if28 ();
    maxpool_row_sequencer_if #(.IMG_IN_SIZE(W4))  if4 ();

    maxpool_row_sequencer #(.IMG_IN_SIZE(W28)) dut28 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start28),
        .abort      (abort28),
        .row_if     (if28.slave),
        .busy       (busy28),
        .frame_done (done28)
    );

    maxpool_row_sequencer #(.IMG_IN_SIZE(W4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .abort      (abort4),
        .row_if     (if4.slave),
        .busy       (busy4),
        .frame_done (done4)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [W28-1:0] src28_q[$];
    logic [O28:0]   exp28_q[$];
    logic [W4-1:0]  src4_q[$];
    logic [O4:0]    exp4_q[$];

    int done_cnt28 = 0, done_cnt4 = 0, out_cnt28 = 0;
    int t_done28 = 0, t_done4 = 0, t_last4 = 0;

    function automatic logic [O28-1:0] pool28(input logic [W28-1:0] a, input logic [W28-1:0] b);
        logic [O28-1:0] r;
        for (int unsigned c = 0; c < O28; c++)
            r[c] = a[2*c] | a[2*c+1] | b[2*c] | b[2*c+1];
        return r;
    endfunction

    task automatic push_rows28(input int unsigned n_rows);
        logic [W28-1:0] ev, od;
        ev = '0;
        for (int unsigned i = 0; i < n_rows; i++) begin
            od = W28'($urandom());
            src28_q.push_back(od);
            if (i % 2 == 0) ev = od;
            else exp28_q.push_back({(i / 2 == O28 - 1), pool28(ev, od)});
        end
    endtask

    // Producers: drive at posedge+1, detect the handshake at the negedge before.
    initial begin : prod28
        bit hs;
        if28.in_row_valid = 1'b0;
        if28.in_row_data  = '0;
        forever begin
            @(negedge clk);
            hs = if28.in_row_valid && if28.in_row_ready;
            @(posedge clk); #1;
            if (hs && src28_q.size() > 0) void'(src28_q.pop_front());
            if (src28_q.size() > 0) begin
                if28.in_row_valid = 1'b1;
                if28.in_row_data  = src28_q[0];
            end else begin
                if28.in_row_valid = 1'b0;
                if28.in_row_data  = '0;
            end
        end
    end

    initial begin : prod4
        bit hs;
        if4.in_row_valid = 1'b0;
        if4.in_row_data  = '0;
        forever begin
            @(negedge clk);
            hs = if4.in_row_valid && if4.in_row_ready;
            @(posedge clk); #1;
            if (hs && src4_q.size() > 0) void'(src4_q.pop_front());
            if (src4_q.size() > 0) begin
                if4.in_row_valid = 1'b1;
                if4.in_row_data  = src4_q[0];
            end else begin
                if4.in_row_valid = 1'b0;
                if4.in_row_data  = '0;
            end
        end
    end

    // Monitors: an output handshake seen at negedge completes at the next posedge.
    initial begin : mon28
        logic [O28:0] e;
        forever begin
            @(negedge clk);
            if (done28) begin done_cnt28++; t_done28 = cyc; end
            if (if28.out_row_valid && if28.out_row_ready) begin
                out_cnt28++;
                if (exp28_q.size() == 0) check_eq("row28_unexpected", 1, 0);
                else begin
                    e = exp28_q.pop_front();
                    check_eq("row28_data", if28.out_row_data, e[O28-1:0]);
                    check_eq("row28_last", if28.out_row_last, e[O28]);
                end
            end
        end
    end

    initial begin : mon4
        logic [O4:0] e;
        forever begin
            @(negedge clk);
            if (done4) begin done_cnt4++; t_done4 = cyc; end
            if (if4.out_row_valid && if4.out_row_ready) begin
                if (if4.out_row_last) t_last4 = cyc;
                if (exp4_q.size() == 0) check_eq("row4_unexpected", 1, 0);
                else begin
                    e = exp4_q.pop_front();
                    check_eq("row4_data", if4.out_row_data, e[O4-1:0]);
                    check_eq("row4_last", if4.out_row_last, e[O4]);
                end
            end
        end
    end

    task automatic pulse_start(input bit sel4, output int t);
        @(posedge clk); #1;
        if (sel4) start4 = 1'b1; else start28 = 1'b1;
        @(negedge clk);
        t = cyc;
        @(posedge clk); #1;
        start4  = 1'b0;
        start28 = 1'b0;
    endtask

    task automatic wait_done(input bit sel4, input int n0, input string tag);
        for (int i = 0; i < 3000 && ((sel4 ? done_cnt4 : done_cnt28) == n0); i++) begin
            @(negedge clk); #1;
        end
        check_eq(tag, sel4 ? done_cnt4 : done_cnt28, n0 + 1);
    endtask

    task automatic wait_empty28(input string tag);
        for (int i = 0; i < 500 && (src28_q.size() + exp28_q.size()) != 0; i++) begin
            @(negedge clk); #1;
        end
        check_eq(tag, src28_q.size() + exp28_q.size(), 0);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t_s, n0, sz, base, i;
        logic [O28-1:0] held;
        if28.out_row_ready = 1'b1;
        if4.out_row_ready  = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check_eq("rst_busy",  busy28, 0);
        check_eq("rst_ready", if28.in_row_ready, 0);
        check_eq("rst_valid", if28.out_row_valid, 0);
        check_eq("rst_last",  if28.out_row_last, 0);
        check_eq("rst_done",  done28, 0);
        check_eq("rst_data",  if28.out_row_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: reset mid-frame after three rows (sequencer waiting in ODD)
        push_rows28(3);
        pulse_start(1'b0, t_s);
        wait_empty28("t1_rows_taken");
        check_eq("t1_ready_pre", if28.in_row_ready, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check_eq("t1_busy",  busy28, 0);
        check_eq("t1_ready", if28.in_row_ready, 0);
        check_eq("t1_valid", if28.out_row_valid, 0);
        check_eq("t1_last",  if28.out_row_last, 0);
        check_eq("t1_done",  done28, 0);
        check_eq("t1_data",  if28.out_row_data, 0);
        src28_q.delete();
        exp28_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check_eq("t1_idle_busy",  busy28, 0);
            check_eq("t1_idle_ready", if28.in_row_ready, 0);
        end

        // 2: hand-picked 4x4 frame
        src4_q.push_back(4'b0001);
        src4_q.push_back(4'b0000);
        src4_q.push_back(4'b1000);
        src4_q.push_back(4'b0100);
        exp4_q.push_back({1'b0, 2'b01});
        exp4_q.push_back({1'b1, 2'b10});
        n0 = done_cnt4;
        pulse_start(1'b1, t_s);
        wait_done(1'b1, n0, "t2_done");
        check_eq("t2_done_after_last", t_done4 - t_last4, 1);
        check_eq("t2_latency", t_done4 - t_s, 3 * O4 + 1);
        check_eq("t2_drain", exp4_q.size(), 0);

        // 3: full random frame, continuous flow
        n0 = done_cnt28;
        push_rows28(W28);
        pulse_start(1'b0, t_s);
        wait_done(1'b0, n0, "t3_done");
        check_eq("t3_latency", t_done28 - t_s, 3 * O28 + 1);
        check_eq("t3_drain", exp28_q.size(), 0);

        // 4: downstream stall on pooled row 5
        n0 = done_cnt28;
        base = out_cnt28;
        push_rows28(W28);
        pulse_start(1'b0, t_s);
        for (i = 0; i < 500 && out_cnt28 < base + 4; i++) begin
            @(negedge clk); #1;
        end
        check_eq("t4_reach_row5", out_cnt28 - base, 4);
        @(posedge clk); #1 if28.out_row_ready = 1'b0;
        for (i = 0; i < 50 && !if28.out_row_valid; i++) begin
            @(negedge clk); #1;
        end
        check_eq("t4_valid", if28.out_row_valid, 1);
        held = if28.out_row_data;
        sz   = src28_q.size();
        check_eq("t4_held_model", held, exp28_q[0][O28-1:0]);
        repeat (10) begin
            @(negedge clk); #1;
            check_eq("t4_stall_data",  if28.out_row_data, held);
            check_eq("t4_stall_valid", if28.out_row_valid, 1);
            check_eq("t4_stall_ready", if28.in_row_ready, 0);
            check_eq("t4_stall_src",   src28_q.size(), sz);
        end
        @(posedge clk); #1 if28.out_row_ready = 1'b1;
        wait_done(1'b0, n0, "t4_done");
        check_eq("t4_drain", exp28_q.size(), 0);

        // 5: abort in ODD after seven rows, then a clean frame
        n0 = done_cnt28;
        push_rows28(7);
        pulse_start(1'b0, t_s);
        wait_empty28("t5_rows_taken");
        check_eq("t5_in_odd", if28.in_row_ready, 1);
        @(posedge clk); #1 abort28 = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_abort_busy",  busy28, 0);
        check_eq("t5_abort_valid", if28.out_row_valid, 0);
        check_eq("t5_abort_ready", if28.in_row_ready, 0);
        abort28 = 1'b0;
        repeat (4) begin @(negedge clk); #1; end
        check_eq("t5_no_done", done_cnt28, n0);
        push_rows28(W28);
        pulse_start(1'b0, t_s);
        wait_done(1'b0, n0, "t5_done");
        check_eq("t5_drain", exp28_q.size(), 0);

        // 6: valid held in IDLE, start re-pulsed while busy
        n0 = done_cnt28;
        push_rows28(W28);
        repeat (5) begin @(negedge clk); #1; end
        check_eq("t6_idle_src",  src28_q.size(), W28);
        check_eq("t6_idle_busy", busy28, 0);
        pulse_start(1'b0, t_s);
        repeat (4) @(posedge clk);
        #1 start28 = 1'b1;
        @(posedge clk); #1 start28 = 1'b0;
        wait_done(1'b0, n0, "t6_done");
        @(negedge clk); #1;
        check_eq("t6_idle_after", busy28, 0);
        check_eq("t6_drain", exp28_q.size() + src28_q.size(), 0);

        check_eq("final_frames28", done_cnt28, 4);
        check_eq("final_frames4",  done_cnt4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
